mem_responder: RTL and testbench

- Single-port word memory acting as the responder side of the CPU memory request interface; serves both instruction fetch and load/store traffic from the multi-cycle core.
- Valid/ready request channel in, valid/ready response channel out, programmable wait states, byte-enable writes, address-range error reporting.
- Sits between the cpu4 core's memory port and the system; also serves as the standard memory model in core benches.

---
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_responder.sv | 148 ++++++++++++++
 tb/tb_mem_responder.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response channel between a requester (CPU core) and mem_responder.
// Request side is valid/ready with byte enables; response side is valid/ready with an error flag.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Single-port word memory answering one request at a time after WAIT_CYCLES wait states.
// Define MEM_RESPONDER_ALIGN_CHECK_EN to report non-word-aligned addresses as errors.
module mem_responder #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic           CLK,
    input  logic           reset,
    mem_responder_if.slave bus,
    output logic           busy
);
    // state  | meaning
    // S_IDLE | ready for a request, nothing outstanding
    // S_WAIT | request latched, counting down wait states
    // S_RESP | response held on the bus until rsp_ready

    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam bit          NO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [3:0]  CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic                  lat_we;
    logic [31:0]           lat_addr;
    logic [31:0]           lat_wdata;
    logic [3:0]            lat_be;

    logic                  accept;
    logic                  commit;
    logic                  acc_we;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_wdata;
    logic [3:0]            acc_be;
    logic [31:0]           offset;
    logic                  range_err;
    logic                  align_err;
    logic                  acc_err;
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           read_val;

    logic [31:0]           mem [DEPTH];

    assign accept = (state == S_IDLE) && bus.req_valid && bus.req_ready;
    assign commit = ((state == S_WAIT) && (cnt == 4'd0)) || (accept && NO_WAIT);

    // With no wait states the access commits on the accept edge, so use the live request.
    assign acc_we    = (state == S_IDLE) ? bus.req_we    : lat_we;
    assign acc_addr  = (state == S_IDLE) ? bus.req_addr  : lat_addr;
    assign acc_wdata = (state == S_IDLE) ? bus.req_wdata : lat_wdata;
    assign acc_be    = (state == S_IDLE) ? bus.req_be    : lat_be;

    assign offset    = acc_addr - BASE_ADDR;
    assign range_err = |offset[31:DEPTH_LOG2+2];
    assign idx       = offset[DEPTH_LOG2+1:2];

    // BASE_ADDR is word aligned, so offset[1:0] equals the address byte lane.
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    assign align_err = |offset[1:0];
`else
    logic unused_lane;
    assign unused_lane = ^offset[1:0];
    assign align_err   = 1'b0;
`endif

    assign acc_err  = range_err | align_err;
    assign read_val = (acc_we || acc_err) ? 32'h0 : mem[idx];

    always_ff @(posedge CLK) begin
        if (!reset && commit && acc_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= 4'd0;
            lat_we        <= 1'b0;
            lat_addr      <= 32'h0;
            lat_wdata     <= 32'h0;
            lat_be        <= 4'h0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 32'h0;
            bus.rsp_err   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat_we        <= bus.req_we;
                        lat_addr      <= bus.req_addr;
                        lat_wdata     <= bus.req_wdata;
                        lat_be        <= bus.req_be;
                        bus.req_ready <= 1'b0;
                        busy          <= 1'b1;
                        if (NO_WAIT) begin
                            state         <= S_RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_rdata <= read_val;
                            bus.rsp_err   <= acc_err;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state         <= S_RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= read_val;
                        bus.rsp_err   <= acc_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= S_IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_rdata <= 32'h0;
                        bus.rsp_err   <= 1'b0;
                        bus.req_ready <= 1'b1;
                        busy          <= 1'b0;
                    end
                end
                default: begin
                    state         <= S_IDLE;
                    bus.req_ready <= 1'b1;
                    bus.rsp_valid <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one default instance (2 wait states) and one with no wait states.
module tb_mem_responder;
    logic CLK = 1'b0;
    logic reset = 1'b1;
    logic busy2, busy0;
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_responder_if bus2();
    mem_responder_if bus0();

    mem_responder dut2 (.CLK(CLK), .reset(reset), .bus(bus2), .busy(busy2));
    mem_responder #(.WAIT_CYCLES(0)) dut0 (.CLK(CLK), .reset(reset), .bus(bus0), .busy(busy0));

    always #5 CLK = ~CLK;

    task automatic send_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, output int lat);
        @(negedge CLK);
        bus2.req_we = we; bus2.req_addr = addr; bus2.req_wdata = wdata; bus2.req_be = be;
        bus2.req_valid = 1'b1;
        @(posedge CLK); #1;
        bus2.req_valid = 1'b0;
        lat = 1;
        while (bus2.rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge CLK); #1;
            lat++;
        end
    endtask

    task automatic finish_rsp();
        @(negedge CLK);
        bus2.rsp_ready = 1'b1;
        @(posedge CLK); #1;
        bus2.rsp_ready = 1'b0;
    endtask

    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rdata, output logic err,
                       output int lat);
        send_req(we, addr, wdata, be, lat);
        rdata = bus2.rsp_rdata;
        err   = bus2.rsp_err;
        finish_rsp();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        n_cmp++; if (bus2.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got %b want 1", bus2.req_ready); end
        n_cmp++; if (bus2.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 0", bus2.rsp_valid); end
        n_cmp++; if (bus2.rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rsp_rdata got %h want 0", bus2.rsp_rdata); end
        n_cmp++; if (bus2.rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_err got %b want 0", bus2.rsp_err); end
        n_cmp++; if (busy2 !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy2); end
        n_cmp++; if (bus0.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready_w0 got %b want 1", bus0.req_ready); end
        @(negedge CLK);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic er; int lat;
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL basic_wr_latency got %0d want 3", lat); end
        n_cmp++; if (er !== 1'b0 || rd !== 32'h0) begin n_bad++; $display("FAIL basic_wr_rsp got err=%b rdata=%h want err=0 rdata=0", er, rd); end
        txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL basic_rd_latency got %0d want 3", lat); end
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL basic_rd_data got %h want deadbeef", rd); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL basic_rd_err got %b want 0", er); end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd; logic er; int lat;
        txn(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
        txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
        txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h11BB33DD) begin n_bad++; $display("FAIL be_merge got %h want 11bb33dd", rd); end
        txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL be_zero_err got %b want 0", er); end
        txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h11BB33DD) begin n_bad++; $display("FAIL be_zero_nochange got %h want 11bb33dd", rd); end
    endtask

    task automatic test_backpressure();
        int lat;
        send_req(1'b0, 32'h10, 32'h0, 4'h0, lat);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL bp_latency got %0d want 3", lat); end
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            n_cmp++; if (bus2.rsp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid_held got %b want 1", bus2.rsp_valid); end
            n_cmp++; if (bus2.rsp_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL bp_data_held got %h want deadbeef", bus2.rsp_rdata); end
            n_cmp++; if (bus2.req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_req_ready got %b want 0", bus2.req_ready); end
            n_cmp++; if (busy2 !== 1'b1) begin n_bad++; $display("FAIL bp_busy got %b want 1", busy2); end
        end
        finish_rsp();
        n_cmp++; if (bus2.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid got %b want 0", bus2.rsp_valid); end
        n_cmp++; if (bus2.rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL bp_release_rdata got %h want 0", bus2.rsp_rdata); end
        n_cmp++; if (bus2.req_ready !== 1'b1 || busy2 !== 1'b0) begin n_bad++; $display("FAIL bp_release_idle got ready=%b busy=%b want ready=1 busy=0", bus2.req_ready, busy2); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic er; int lat;
        txn(1'b1, 32'h0, 32'h0BADF00D, 4'hF, rd, er, lat);
        txn(1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL oor_rd_err got %b want 1", er); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL oor_rd_data got %h want 0", rd); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL oor_latency got %0d want 3", lat); end
        txn(1'b1, 32'h1000, 32'h55555555, 4'hF, rd, er, lat);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL oor_wr_err got %b want 1", er); end
        txn(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h0BADF00D) begin n_bad++; $display("FAIL oor_wr_suppressed got %h want 0badf00d", rd); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL word0_err got %b want 0", er); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd; logic er; int lat; bit seen;
        txn(1'b1, 32'h30, 32'h5A5A5A5A, 4'hF, rd, er, lat);
        @(negedge CLK);
        bus2.req_we = 1'b1; bus2.req_addr = 32'h30; bus2.req_wdata = 32'hCAFEF00D; bus2.req_be = 4'hF;
        bus2.req_valid = 1'b1;
        @(posedge CLK); #1;
        bus2.req_valid = 1'b0;
        @(negedge CLK);
        reset = 1'b1;
        @(posedge CLK); #1;
        n_cmp++; if (bus2.rsp_valid !== 1'b0 || busy2 !== 1'b0) begin n_bad++; $display("FAIL midwait_reset got valid=%b busy=%b want 0 0", bus2.rsp_valid, busy2); end
        @(negedge CLK);
        reset = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(posedge CLK); #1;
            if (bus2.rsp_valid !== 1'b0) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midwait_no_rsp got %b want 0", seen); end
        txn(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h5A5A5A5A) begin n_bad++; $display("FAIL midwait_no_write got %h want 5a5a5a5a", rd); end
    endtask

    task automatic test_align();
        logic [31:0] rd; logic er; int lat;
        txn(1'b0, 32'h12, 32'h0, 4'h0, rd, er, lat);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL align_rd got err=%b rdata=%h want err=1 rdata=0", er, rd); end
`else
        n_cmp++; if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL align_rd got err=%b rdata=%h want err=0 rdata=deadbeef", er, rd); end
`endif
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL align_latency got %0d want 3", lat); end
    endtask

    task automatic test_back_to_back();
        int n; int lat; logic rdy;
        @(negedge CLK);
        bus2.rsp_ready = 1'b1;
        bus2.req_we = 1'b1; bus2.req_addr = 32'h50; bus2.req_wdata = 32'h0F0F1234; bus2.req_be = 4'hF;
        bus2.req_valid = 1'b1;
        @(posedge CLK); #1;
        bus2.req_we = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge CLK);
            rdy = bus2.req_ready;
            @(posedge CLK);
            n++;
            if (rdy === 1'b1) break;
        end
        #1;
        bus2.req_valid = 1'b0;
        n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL b2b_spacing got %0d want 4", n); end
        lat = 1;
        while (bus2.rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge CLK); #1;
            lat++;
        end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL b2b_rd_latency got %0d want 3", lat); end
        n_cmp++; if (bus2.rsp_rdata !== 32'h0F0F1234) begin n_bad++; $display("FAIL b2b_hazard got %h want 0f0f1234", bus2.rsp_rdata); end
        @(posedge CLK); #1;
        bus2.rsp_ready = 1'b0;
    endtask

    task automatic test_zero_wait();
        int lat;
        @(negedge CLK);
        bus0.req_we = 1'b1; bus0.req_addr = 32'h40; bus0.req_wdata = 32'h600DCAFE; bus0.req_be = 4'hF;
        bus0.req_valid = 1'b1;
        @(posedge CLK); #1;
        bus0.req_valid = 1'b0;
        lat = 1;
        while (bus0.rsp_valid !== 1'b1 && lat < 40) begin @(posedge CLK); #1; lat++; end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL w0_wr_latency got %0d want 1", lat); end
        @(negedge CLK); bus0.rsp_ready = 1'b1;
        @(posedge CLK); #1; bus0.rsp_ready = 1'b0;
        @(negedge CLK);
        bus0.req_we = 1'b0;
        bus0.req_valid = 1'b1;
        @(posedge CLK); #1;
        bus0.req_valid = 1'b0;
        lat = 1;
        while (bus0.rsp_valid !== 1'b1 && lat < 40) begin @(posedge CLK); #1; lat++; end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL w0_rd_latency got %0d want 1", lat); end
        n_cmp++; if (bus0.rsp_rdata !== 32'h600DCAFE || bus0.rsp_err !== 1'b0) begin n_bad++; $display("FAIL w0_rd_data got %h err=%b want 600dcafe err=0", bus0.rsp_rdata, bus0.rsp_err); end
        @(negedge CLK); bus0.rsp_ready = 1'b1;
        @(posedge CLK); #1; bus0.rsp_ready = 1'b0;
    endtask

    initial begin
        bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = 32'h0; bus2.req_wdata = 32'h0;
        bus2.req_be = 4'h0; bus2.rsp_ready = 1'b0;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = 32'h0; bus0.req_wdata = 32'h0;
        bus0.req_be = 4'h0; bus0.rsp_ready = 1'b0;
        test_reset();
        test_basic();
        test_byte_enable();
        test_backpressure();
        test_out_of_range();
        test_reset_mid_wait();
        test_align();
        test_back_to_back();
        test_zero_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
